// File: rtl/axis_wait_buffer_pkg.sv
// Shared types for the AXI-Stream store-and-delay buffer.
package axis_wait_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Address width for a DEPTH-entry frame store; a 1-entry store still needs a 1-bit pointer.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axis_wait_buffer_counter.sv
// Hold-time down counter: loads the programmed wait, counts down, flags the last wait cycle.
module wait_down_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] load_val_i,
  input  logic                 en_i,
  output logic                 one_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Saturates at zero so an idle enable can never wrap to the maximum.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                        cnt_d = load_val_i;
    else if (en_i && (cnt_q != '0))    cnt_d = cnt_q - CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign one_o = (cnt_q == CNT_WIDTH'(1));

endmodule

// File: rtl/axis_wait_buffer.sv
// Frame store-and-delay AXI-Stream buffer: FILL -> WAIT (programmable) -> DRAIN.
// Define AXIS_WAIT_TLAST_EN to let s_last close frames; otherwise every frame is DEPTH words.
module axis_wait_buffer
  import axis_wait_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CNT_WIDTH-1:0]    wait_cycles,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_last,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    ex_start,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  frame_len
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  state_e                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         len_q, len_d;
  logic                  ex_start_q, ex_start_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  acc, close, tlast_close, cnt_one, m_hs;

`ifdef AXIS_WAIT_TLAST_EN
  assign tlast_close = s_last;
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign tlast_close   = 1'b0;
`endif

  assign s_ready   = (state_q == FILL);
  assign acc       = s_valid & s_ready;
  assign close     = acc & (tlast_close | (wr_ptr_q == PW'(DEPTH - 1)));
  assign m_valid   = (state_q == DRAIN);
  assign m_hs      = m_valid & m_ready;
  assign m_last    = m_valid & ({1'b0, rd_ptr_q} == len_q - LW'(1));
  assign m_data    = mem[rd_ptr_q];
  assign busy      = (state_q == WAIT) | (state_q == DRAIN);
  assign ex_start  = ex_start_q;
  assign frame_len = len_q;

  wait_down_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (close),
    .load_val_i (wait_cycles),
    .en_i       (state_q == WAIT),
    .one_o      (cnt_one)
  );

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    len_d    = len_q;
    unique case (state_q)
      FILL: begin
        if (close) begin
          len_d    = LW'(wr_ptr_q) + LW'(1);
          wr_ptr_d = '0;
          state_d  = (wait_cycles == '0) ? DRAIN : WAIT;
        end else if (acc) begin
          wr_ptr_d = wr_ptr_q + PW'(1);
        end
      end
      WAIT:  if (cnt_one) state_d = DRAIN;
      DRAIN: begin
        if (m_hs) begin
          if (m_last) begin
            rd_ptr_d = '0;
            state_d  = FILL;
          end else begin
            rd_ptr_d = rd_ptr_q + PW'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
    // Pulse on the cycle the FSM first sits in DRAIN.
    ex_start_d = (state_d == DRAIN) && (state_q != DRAIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      len_q      <= '0;
      ex_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      len_q      <= len_d;
      ex_start_q <= ex_start_d;
    end
  end

  // Frame store is plain LUT RAM: no reset, combinational read port.
  always_ff @(posedge clk) begin
    if (acc) mem[wr_ptr_q] <= s_data;
  end

endmodule

// File: tb/tb_axis_wait_buffer.sv
// Self-checking bench for axis_wait_buffer: per-frame vector table, reset abort, random vs. model.
module tb_axis_wait_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CW    = 8;
`ifdef AXIS_WAIT_TLAST_EN
  localparam bit TLAST = 1'b1;
`else
  localparam bit TLAST = 1'b0;
`endif

  logic          clk, rst;
  logic [CW-1:0] wait_cycles;
  logic [DW-1:0] s_data, m_data;
  logic          s_valid, s_ready, s_last, m_valid, m_ready, m_last, ex_start, busy;
  logic [4:0]    frame_len;

  int n_cmp = 0;
  int n_err = 0;

  axis_wait_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .wait_cycles(wait_cycles),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .ex_start(ex_start), .busy(busy), .frame_len(frame_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One frame: offered words, wait, m_ready pattern, expected length and release latency.
  typedef struct {
    int          wait_c;
    int          last_at;   // word index carrying s_last, -1 for none
    logic [31:0] base;
    logic [31:0] step;
    logic [31:0] mask;      // m_ready per drain cycle, LSB first, repeating
    int          abort;     // assert reset after this many transfers, -1 for none
    int          exp_len;
    int          exp_lat;   // samples after the closing edge until first m_valid (1 = next cycle)
  } vec_t;

  vec_t vecs[7];

  task automatic idle();
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0; wait_cycles = '0;
  endtask

  task automatic run_frame(input vec_t v);
    logic [CW-1:0] w, junk;
    int lat, k, cyc;
    w    = CW'(v.wait_c);
    junk = w ^ 8'h5A;
    for (int i = 0; i < v.exp_len; i++) begin
      @(negedge clk);
      chk("fill_ready", s_ready, 1'b1);
      if (i == 0) chk("fill_busy", busy, 1'b0);
      s_valid     = 1'b1;
      s_data      = v.base + v.step * i;
      s_last      = (i == v.last_at);
      wait_cycles = (i == v.exp_len - 1) ? w : junk;
      m_ready     = 1'b1;
    end
    @(negedge clk);
    chk("close_ready", s_ready, 1'b0);
    // Keep offering a word: it must be held off, not swallowed.
    s_data = 32'hBADBAD00; s_last = 1'b1; wait_cycles = junk;
    lat = 1;
    while (!m_valid && lat < 400) begin
      chk("wait_ready", s_ready, 1'b0);
      chk("wait_busy", busy, 1'b1);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, v.exp_lat);
    chk("frame_len", frame_len, v.exp_len);
    k = 0; cyc = 0;
    while (k < v.exp_len && cyc < 200) begin
      if (k == v.abort) begin
        rst = 1'b0;
        #1;
        chk("abort_mvalid", m_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_exstart", ex_start, 1'b0);
        chk("abort_ready", s_ready, 1'b1);
        idle();
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      chk("drain_valid", m_valid, 1'b1);
      chk("drain_data", m_data, v.base + v.step * k);
      chk("drain_last", m_last, k == v.exp_len - 1);
      chk("drain_exstart", ex_start, cyc == 0);
      chk("drain_ready", s_ready, 1'b0);
      m_ready = v.mask[cyc % 32];
      if (m_ready) k++;
      cyc++;
      @(negedge clk);
    end
    chk("xfer_count", k, v.exp_len);
    s_valid = 1'b0;
    chk("done_valid", m_valid, 1'b0);
    chk("done_ready", s_ready, 1'b1);
    chk("done_busy", busy, 1'b0);
  endtask

  // Random-phase reference: frames as word queues, release time from plain arithmetic.
  logic [31:0] q[$];
  int          mode, rel, idx, len;

  initial begin
    vecs[0] = '{3,   3, 32'h11,       32'h11, 32'hFFFF_FFFF, -1, TLAST ? 4 : DEPTH, 4};
    vecs[1] = '{2,  -1, 32'h100,      32'h1,  32'hFFFF_FFFF, -1, DEPTH,             3};
    vecs[2] = '{0,   0, 32'hDEADBEEF, 32'h0,  32'hFFFF_FFFF, -1, TLAST ? 1 : DEPTH, 1};
    vecs[3] = '{1,   2, 32'hA0,       32'h1,  32'hFFFF_FFF9, -1, TLAST ? 3 : DEPTH, 2};
    vecs[4] = '{1,   4, 32'h500,      32'h3,  32'hFFFF_FFFF,  2, TLAST ? 5 : DEPTH, 2};
    vecs[5] = '{0,   1, 32'h600,      32'h7,  32'hFFFF_FFFF, -1, TLAST ? 2 : DEPTH, 1};
    vecs[6] = '{255, 1, 32'h700,      32'h1,  32'hFFFF_FFF5, -1, TLAST ? 2 : DEPTH, 256};

    idle();
    rst = 1'b1;
    #2 rst = 1'b0;
    #4;
    chk("rst_ready", s_ready, 1'b1);
    chk("rst_mvalid", m_valid, 1'b0);
    chk("rst_mlast", m_last, 1'b0);
    chk("rst_exstart", ex_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_len", frame_len, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) run_frame(vecs[i]);

    mode = 0; rel = 0; idx = 0; len = 0;
    q.delete();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      begin
        bit drain;
        drain = (mode == 1) && (n >= rel);
        chk("rnd_ready", s_ready, mode == 0);
        chk("rnd_busy", busy, mode == 1);
        chk("rnd_mvalid", m_valid, drain);
        chk("rnd_exstart", ex_start, drain && (n == rel));
        if (drain) begin
          chk("rnd_data", m_data, q[idx]);
          chk("rnd_last", m_last, idx == len - 1);
          chk("rnd_len", frame_len, len);
        end
        s_valid     = ($urandom % 4) != 0;
        s_data      = $urandom;
        s_last      = ($urandom % 6) == 0;
        m_ready     = ($urandom % 3) != 0;
        wait_cycles = CW'($urandom % 5);
        if (mode == 0 && s_valid) begin
          q.push_back(s_data);
          if ((TLAST && s_last) || q.size() == DEPTH) begin
            len  = q.size();
            mode = 1;
            rel  = n + 1 + int'(wait_cycles);
            idx  = 0;
          end
        end else if (drain && m_ready) begin
          idx++;
          if (idx == len) begin
            mode = 0;
            q.delete();
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_wait_buffer.md
Name: axis_wait_buffer

Overview:
- Frame-granular AXI-Stream store-and-delay buffer: captures one frame of up to DEPTH words, holds it for a runtime-programmable number of cycles, then replays it on the master port.
- Sits between CNN stages, such as the input DMA and the convolution engine. It paces data release, and ex_start tells the downstream engine that a frame is ready.
- Successor to the fixed-depth wait datapath. Adds full controller FSM, runtime wait length, variable frame length, backpressure and frame-length reporting.

Parameters:
- DATA_WIDTH, 32, stream word width.
- DEPTH, 16, maximum words per frame; power of two, ≥2.
- CNT_WIDTH, 8, wait-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wait_cycles  in  CNT_WIDTH  hold time in cycles; sampled when the frame closes.
- s_data  in  DATA_WIDTH  slave data.
- s_valid  in  1  slave valid.
- s_ready  out  1  slave ready.
- s_last  in  1  slave end-of-frame.
- m_data  out  DATA_WIDTH  master data.
- m_valid  out  1  master valid.
- m_ready  in  1  master ready.
- m_last  out  1  master end-of-frame.
- ex_start  out  1  one-cycle pulse on the first cycle of DRAIN.
- busy  out  1  high in WAIT and DRAIN.
- frame_len  out  $clog2(DEPTH)+1  word count of the stored frame.

Behaviour:
- Reset (rst=0, async): state=FILL, wr_ptr=0, rd_ptr=0, wait counter=0, frame_len=0, s_ready=1. Also m_valid=0, m_last=0, ex_start=0, busy=0. Memory contents are not cleared. A reset in WAIT or DRAIN abandons the frame, and no partial output follows.
- FILL:
  - s_ready=1.
  - Handshake (s_valid&s_ready) writes s_data to mem[wr_ptr] and increments wr_ptr.
  - The frame closes on the accepted word with s_last=1, or on the DEPTH-th accepted word (forced close; s_last ignored).
  - On close: frame_len = words accepted, wait_cycles latched into the counter, and next state is WAIT. If the latched value is 0, next state is DRAIN.
- WAIT:
  - s_ready=0 and busy=1.
  - The counter decrements each cycle. When it reaches 1, next state is DRAIN.
  - WAIT lasts exactly wait_cycles cycles.
- DRAIN:
  - m_valid=1 and m_data=mem[rd_ptr], read combinationally from LUT RAM.
  - m_last=1 when rd_ptr==frame_len-1.
  - Handshake increments rd_ptr.
  - A handshake with m_last=1 returns the block to FILL, with wr_ptr=0 and rd_ptr=0.
  - m_data, m_last and m_valid stay stable while m_valid&!m_ready.
  - ex_start pulses only in the first DRAIN cycle.
- Latency:
  - Closing word accepted at edge T. The first m_valid cycle begins at T+1+W for W≥1, and at T+1 for W=0.
  - Minimum frame turnaround is frame_len+W+1 cycles.
- Boundary conditions:
  - A single-word frame (s_last on the first word) gives frame_len=1, and m_last is asserted together with the first m_valid.
  - Words arriving outside FILL are back-pressured, never dropped.
  - wait_cycles changes outside the close cycle have no effect.
  - The wait counter never wraps; the maximum is 2^CNT_WIDTH-1.

Optional Feature:
- AXIS_WAIT_TLAST_EN defined: s_last closes frames as described above, and m_last is generated.
- Undefined:
  - s_last is ignored.
  - Every frame is exactly DEPTH words.
  - m_last is still driven on the final word, and frame_len always equals DEPTH.

Decomposition:
- Package axis_wait_pkg holds:
  - state encoding constants FILL=2'd0, WAIT=2'd1, DRAIN=2'd2;
  - a pointer-width localparam helper.
- One natural sub-module: wait_down_counter, with load, enable and reach-one flag.
- Memory stays an inline array.

Test Plan:
- Frame of 4 words (0x11..0x44, s_last on 4th), wait_cycles=3, m_ready=1:
  - output is 0x11..0x44 with m_last on 0x44;
  - first m_valid comes 4 cycles after the closing handshake;
  - ex_start pulses once;
  - frame_len=4.
- Frame of 16 words with no s_last, DEPTH=16:
  - forced close after word 16;
  - s_ready=0 on the next cycle;
  - output 16 words with m_last on the 16th.
- wait_cycles=0, 1-word frame 0xDEADBEEF:
  - m_valid=1 and m_last=1 on the cycle after acceptance.
- Frame of 3 words with m_ready toggled 1,0,0,1,1:
  - m_data held while stalled;
  - exactly 3 transfers, in order;
  - block returns to FILL with s_ready=1.
- Assert rst=0 mid-DRAIN after 2 of 5 words:
  - m_valid, busy and ex_start drop immediately;
  - after release, s_ready=1 and a new 2-word frame replays correctly.
- Macro undefined, stimulus of s_last on word 2:
  - no close occurs;
  - frame closes only at word DEPTH.
